// File: rtl/bcd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_decoder_pkg
//  Purpose  : Shared widths and helper functions for the registered 3-to-8
//             decoder: one-hot decode of a 3-bit selector and the idle
//             (inactive) output pattern for either output polarity.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  // Bit index of the single set bit equals the selector value.
  function automatic logic [OUT_W-1:0] onehot3to8(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction

  // Pattern driven when nothing is selected: all bits deasserted, which is
  // all-ones for an active-low output.
  function automatic logic [OUT_W-1:0] inactive_pattern(input logic active_low);
    return active_low ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

endpackage : bcd_decoder_pkg
`default_nettype wire

// File: rtl/bcd_decoder_core.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_decoder_core
//  Purpose  : Purely combinational 3-to-8 decode with output polarity.
//  Params   : ACTIVE_LOW - 0: selected bit is 1; 1: all bits inverted
//  Ports    : sel [2:0] in  - binary selector
//             dec [7:0] out - one-hot (or one-cold) decode of sel
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_decoder_core
  import bcd_decoder_pkg::*;
#(
  parameter int ACTIVE_LOW = 0
) (
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] dec
);

  localparam logic c_invert = (ACTIVE_LOW != 0);

  logic [OUT_W-1:0] w_onehot;

  assign w_onehot = onehot3to8(sel);
  assign dec      = c_invert ? ~w_onehot : w_onehot;

endmodule : bcd_decoder_core
`default_nettype wire

// File: rtl/bcd_decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_decoder_3to8
//  Purpose  : Registered 3-to-8 line decoder with enable gating and optional
//             code-change statistics.
//  Params   : ACTIVE_LOW - output polarity (0: active-high, 1: 74x138 style)
//             CNT_W      - width of the saturating code-change counter
//  Macro    : BCD_DECODER_STATS_EN - when defined, builds the changed pulse
//             and chg_cnt counter; otherwise both outputs are tied to 0.
//  Ports    : clk      in   - clock, rising edge
//             rst_n    in   - asynchronous active-low reset
//             en       in   - decode enable
//             a, b, c  in   - selector, a is the MSB
//             out      out  - registered decode, bit index = {a,b,c}
//             valid    out  - registered copy of en
//             code     out  - registered selector (holds while en=0)
//             changed  out  - one-cycle pulse on a new valid code
//             chg_cnt  out  - saturating count of changed pulses
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_decoder_3to8
  import bcd_decoder_pkg::*;
#(
  parameter int ACTIVE_LOW = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic [SEL_W-1:0] code,
  output logic             changed,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [OUT_W-1:0] c_idle = inactive_pattern(ACTIVE_LOW != 0);

  logic [SEL_W-1:0] w_sel;
  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] w_out_next;

  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic [SEL_W-1:0] r_code;

  assign w_sel = {a, b, c};

  bcd_decoder_core #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .sel (w_sel),
    .dec (w_dec)
  );

  assign w_out_next = en ? w_dec : c_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= c_idle;
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_out   <= w_out_next;
      r_valid <= en;
      if (en) begin
        r_code <= w_sel;
      end
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign code  = r_code;

`ifdef BCD_DECODER_STATS_EN
  logic             w_changed;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;

  // A sample is "new" if the previous cycle held no valid code (after reset
  // or en=0) or if it differs from the last captured code.
  assign w_changed = en && (!r_valid || (w_sel != r_code));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_changed <= w_changed;
      if (w_changed && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign changed = r_changed;
  assign chg_cnt = r_cnt;
`else
  assign changed = 1'b0;
  assign chg_cnt = '0;
`endif

endmodule : bcd_decoder_3to8
`default_nettype wire

// File: tb/tb_bcd_decoder_3to8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_decoder_3to8
//  Purpose  : Scoreboard bench for bcd_decoder_3to8. Two instances share the
//             inputs: one active-high with a 16-bit counter, one active-low
//             with a 2-bit counter (saturation). Expected values come from a
//             behavioural model and are queued; a monitor compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_decoder_3to8;

`ifdef BCD_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic en;
  logic a, b, c;

  logic [7:0]  out0, out1;
  logic        valid0, valid1;
  logic [2:0]  code0, code1;
  logic        changed0, changed1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  bcd_decoder_3to8 #(.ACTIVE_LOW(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .out(out0), .valid(valid0), .code(code0), .changed(changed0), .chg_cnt(cnt0)
  );

  bcd_decoder_3to8 #(.ACTIVE_LOW(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c),
    .out(out1), .valid(valid1), .code(code1), .changed(changed1), .chg_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  out0;
    logic [7:0]  out1;
    logic        valid;
    logic [2:0]  code;
    logic        changed;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid = 0;
  int m_code  = 0;
  int m_cnt0  = 0;
  int m_cnt1  = 0;
  bit prev_rst = 1;
  int last_sel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_now();
    chk("async_out0",  32'(out0),     32'h00);
    chk("async_out1",  32'(out1),     32'hFF);
    chk("async_valid", 32'(valid0),   32'h0);
    chk("async_code",  32'(code0),    32'h0);
    chk("async_chg",   32'(changed0), 32'h0);
    chk("async_cnt0",  32'(cnt0),     32'h0);
    chk("async_cnt1",  32'(cnt1),     32'h0);
  endtask

  // Applies one cycle of stimulus and queues the response expected after the
  // following rising edge.
  task automatic step(input bit rst, input bit e, input int sel);
    exp_t x;
    bit ch;
    @(negedge clk);
    rst_n = rst;
    en    = e;
    {a, b, c} = 3'(sel);
    if (!rst && prev_rst) begin
      #1;
      chk_reset_now();
    end
    prev_rst = rst;
    if (!rst) begin
      m_valid = 0; m_code = 0; m_cnt0 = 0; m_cnt1 = 0;
      ch = 0;
    end else begin
      ch = STATS && e && (!m_valid || sel != m_code);
      if (ch) begin
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 3)     m_cnt1++;
      end
      if (e) begin
        m_valid = 1;
        m_code  = sel;
      end else begin
        m_valid = 0;
      end
    end
    x.valid   = rst && e;
    x.out0    = x.valid ? 8'(1 << sel) : 8'h00;
    x.out1    = ~x.out0;
    x.code    = 3'(m_code);
    x.changed = ch;
    x.cnt0    = 16'(m_cnt0);
    x.cnt1    = 2'(m_cnt1);
    sb.push_back(x);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered result.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("out_hi",  32'(out0),     32'(x.out0));
        chk("out_lo",  32'(out1),     32'(x.out1));
        chk("valid",   32'(valid0),   32'(x.valid));
        chk("valid_l", 32'(valid1),   32'(x.valid));
        chk("code",    32'(code0),    32'(x.code));
        chk("code_l",  32'(code1),    32'(x.code));
        chk("changed", 32'(changed0), 32'(x.changed));
        chk("chg_l",   32'(changed1), 32'(x.changed));
        chk("cnt16",   32'(cnt0),     32'(x.cnt0));
        chk("cnt2",    32'(cnt1),     32'(x.cnt1));
      end
    end
  end

  initial begin
    int s;
    rst_n = 1'b1;
    en    = 1'b0;
    {a, b, c} = 3'b000;

    // Reset, then idle after release: outputs keep reset values
    repeat (3) step(0, 0, 0);
    repeat (3) step(1, 0, 3);

    // Exhaustive sweep, each code held 10 cycles
    for (int i = 0; i < 8; i++)
      repeat (10) step(1, 1, i);

    // Enable gating with sel=101
    repeat (2) step(1, 0, 5);
    repeat (3) step(1, 1, 5);

    // Saturation sequence after a fresh reset
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0); step(1, 1, 1); step(1, 1, 1);
    step(1, 1, 2); step(1, 1, 3); step(1, 1, 4);
    repeat (2) step(1, 1, 4);

    // Reset in mid-run with sel=110
    step(1, 1, 5);
    repeat (3) step(1, 1, 6);
    step(0, 1, 6);
    repeat (3) step(1, 1, 6);

    // Randomised traffic with occasional resets and held codes
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 2) == 0) ? last_sel : int'($urandom_range(0, 7));
      last_sel = s;
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), s);
    end

    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_bcd_decoder_3to8
`default_nettype wire
